mips_mc_main_control: RTL and testbench

//  Multi-cycle main control FSM; produces alu_op[1:0] for the ALU-control decoder and consumes its jr flag.

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/mips_mc_ctrl_decode.sv | 115 +++++++++++
 rtl/mips_mc_main_control.sv | 92 +++++++++
 tb/tb_mips_mc_main_control.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM state encodings and datapath select codes shared by the multi-cycle MIPS control
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ORIEX  = 4'd12,
        S_IWB    = 4'd13,
        S_JR     = 4'd14
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// mips_mc_ctrl_decode: combinational decode of FSM state (plus mem_ready, zero, op) into datapath controls
//   in : state, mem_ready, zero, op
//   out: pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg, reg_write,
//        alu_src_a, alu_src_b, alu_op, pc_source, illegal_op
module mips_mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic [5:0] op,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op
);

    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        illegal_op    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state)
            S_FETCH: begin
                // PC+4 and IR latch together on the single cycle the fetch completes
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // speculative branch target lands in ALUOut for a possible BEQ
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = !op_legal(op);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                mdr_write = mem_ready;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ORI;
            end
            S_IWB: reg_write = 1'b1;
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCS_REGA;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: rtl/mips_mc_main_control.sv
// mips_mc_main_control: multi-cycle MIPS32 main control FSM (state register + next-state logic)
//   in : clk, rst_n (sync, active-low), op, zero, jr, mem_ready
//   out: datapath controls from mips_mc_ctrl_decode, state_dbg (current state encoding)
module mips_mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               jr,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= S_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = jr ? S_JR : S_RWB;
            S_ADDIEX: state_d = S_IWB;
            S_ORIEX:  state_d = S_IWB;
            // writeback, branch and jump states, plus the unused encoding, all return to fetch
            default:  state_d = S_FETCH;
        endcase
    end

    mips_mc_ctrl_decode u_decode (
        .state      (state_q),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .op         (op),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op)
    );

    assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_main_control.sv
// tb_mips_mc_main_control: randomized instruction-level check of the multi-cycle main control FSM
module tb_mips_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       jr = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, mdr_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;
    logic [17:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    localparam int K_R = 0, K_JR = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ADDI = 6, K_ORI = 7, K_ILL = 8;

    always #5 clk = ~clk;

    mips_mc_main_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .jr         (jr),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    assign obs = {pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] opcode_of(input int k);
        case (k)
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_BEQ:   return 6'b000100;
            K_J:     return 6'b000010;
            K_ADDI:  return 6'b001000;
            K_ORI:   return 6'b001101;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] o;
        do o = 6'($urandom); while (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001101});
        return o;
    endfunction

    // each control line expressed as the set of states (and handshake) where the rules say it is high
    function automatic logic [17:0] model_out(input int s, input logic mr, input logic z, input logic ill);
        logic pcw, pcc;
        logic [1:0] srcb, aop, psrc;
        pcw  = (s == 1 && mr) || s == 10 || s == 14;
        pcc  = s == 9;
        srcb = s == 1 ? 2'd1 : s == 2 ? 2'd3 : (s inside {3, 11, 12}) ? 2'd2 : 2'd0;
        aop  = s == 7 ? 2'd2 : s == 9 ? 2'd1 : s == 12 ? 2'd3 : 2'd0;
        psrc = s == 9 ? 2'd1 : s == 10 ? 2'd2 : s == 14 ? 2'd3 : 2'd0;
        return {pcw | (pcc & z), (s == 4 || s == 6), (s == 1 || s == 4), (s == 6),
                (s == 1 && mr), (s == 4 && mr), (s == 8), (s == 5),
                (s inside {5, 8, 13}), (s inside {3, 7, 9, 11, 12}), srcb, aop, psrc, (s == 2 && ill)};
    endfunction

    // entered and left at posedge+1; holds reset for n edges, then one RESET cycle with rst_n high
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            op = 6'($urandom); zero = 1'($urandom); jr = 1'($urandom); mem_ready = 1'($urandom);
            #3;
            check("rst_state", state_dbg, 0);
            check("rst_outputs", obs, 0);
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #3;
        check("rst_release_state", state_dbg, 0);
        check("rst_release_outputs", obs, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input int k, input int fw, input int mw, input logic z, input logic [5:0] opc, input bit abort);
        int st[$];
        logic rdy[$];
        int c_ir = 0, c_mdr = 0, c_rw = 0, c_pc = 0, c_ill = 0, c_mw = 0;
        for (int i = 0; i <= fw; i++) begin st.push_back(1); rdy.push_back(i == fw); end
        st.push_back(2); rdy.push_back(1'($urandom));
        case (k)
            K_R:    begin st.push_back(7); st.push_back(8); end
            K_JR:   begin st.push_back(7); st.push_back(14); end
            K_LW: begin
                st.push_back(3); rdy.push_back(1'($urandom));
                for (int i = 0; i <= mw; i++) begin st.push_back(4); rdy.push_back(i == mw); end
                st.push_back(5);
            end
            K_SW: begin
                st.push_back(3); rdy.push_back(1'($urandom));
                for (int i = 0; i <= mw; i++) begin st.push_back(6); rdy.push_back(i == mw); end
            end
            K_BEQ:  st.push_back(9);
            K_J:    st.push_back(10);
            K_ADDI: begin st.push_back(11); st.push_back(13); end
            K_ORI:  begin st.push_back(12); st.push_back(13); end
            default: ;
        endcase
        while (rdy.size() < st.size()) rdy.push_back(1'($urandom));
        for (int i = 0; i < st.size(); i++) begin
            if (abort && i > 0 && st[i] == 4 && st[i-1] == 4) return;
            op = (st[i] == 1) ? 6'($urandom) : opc;
            zero = (st[i] == 9) ? z : 1'($urandom);
            jr = (st[i] == 7) ? (k == K_JR) : 1'($urandom);
            mem_ready = rdy[i];
            #3;
            check($sformatf("state k%0d c%0d", k, i), state_dbg, st[i]);
            check($sformatf("outputs k%0d s%0d", k, st[i]), obs, model_out(st[i], rdy[i], zero, k == K_ILL));
            c_ir += int'(ir_write); c_mdr += int'(mdr_write); c_rw += int'(reg_write);
            c_pc += int'(pc_en); c_ill += int'(illegal_op); c_mw += int'(mem_write);
            @(posedge clk); #1;
        end
        check($sformatf("ir_write_count k%0d", k), c_ir, 1);
        check($sformatf("mdr_write_count k%0d", k), c_mdr, k == K_LW);
        check($sformatf("reg_write_count k%0d", k), c_rw, k inside {K_R, K_LW, K_ADDI, K_ORI});
        check($sformatf("pc_en_count k%0d", k), c_pc, 1 + int'(k == K_J || k == K_JR || (k == K_BEQ && z)));
        check($sformatf("illegal_count k%0d", k), c_ill, k == K_ILL);
        check($sformatf("mem_write_cycles k%0d", k), c_mw, k == K_SW ? mw + 1 : 0);
    endtask

    initial begin
        do_reset(2);
        run_instr(K_LW, 3, 3, 1'b0, opcode_of(K_LW), 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1, opcode_of(K_BEQ), 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b0, opcode_of(K_BEQ), 1'b0);
        run_instr(K_R, 0, 0, 1'b0, opcode_of(K_R), 1'b0);
        run_instr(K_JR, 0, 0, 1'b0, opcode_of(K_JR), 1'b0);
        run_instr(K_ILL, 0, 0, 1'b0, 6'b111111, 1'b0);
        run_instr(K_ORI, 1, 0, 1'b0, opcode_of(K_ORI), 1'b0);
        run_instr(K_ADDI, 0, 0, 1'b0, opcode_of(K_ADDI), 1'b0);
        run_instr(K_SW, 0, 2, 1'b0, opcode_of(K_SW), 1'b0);
        run_instr(K_J, 2, 0, 1'b0, opcode_of(K_J), 1'b0);
        run_instr(K_LW, 0, 5, 1'b0, opcode_of(K_LW), 1'b1);
        do_reset(2);
        repeat (200) begin
            int k;
            k = $urandom_range(0, 8);
            run_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      k == K_ILL ? rand_illegal() : opcode_of(k), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
